// File: rtl/snake_body_ctrl.sv
// snake_body_ctrl
// Keeps the snake body as a circular buffer of packed {row, col} positions.
// Each accepted game step computes the new head, scans the body for a
// self-hit, and sequences pixel off/on writes into the LED-matrix
// framebuffer over a valid/ready port. After reset the whole 8x16
// framebuffer is cleared and the initial snake is drawn.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   step            one-cycle request to advance (honoured only in IDLE)
//   dir             00 up, 01 right, 10 down, 11 left
//   grow            lengthen by one on the accepted step
//   busy            high whenever not IDLE
//   done            one-cycle pulse on return to IDLE after a step
//   collision       sticky self-hit flag, cleared only by rst
//   length          current segment count
//   head_pos        current head {row, col}
//   tail_pos        current tail {row, col}
//   px_valid        pixel write request
//   px_pos          pixel address {1'b0, row[2:0], col[3:0]}
//   px_on           1 = light, 0 = clear
//   px_ready        framebuffer accepts the write this cycle
module snake_body_ctrl #(
    parameter int         MAX_LEN   = 32,
    parameter int         INIT_LEN  = 3,
    parameter logic [7:0] INIT_HEAD = 8'h34
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           step,
    input  logic [1:0]                     dir,
    input  logic                           grow,
    output logic                           busy,
    output logic                           done,
    output logic                           collision,
    output logic [$clog2(MAX_LEN+1)-1:0]   length,
    output logic [7:0]                     head_pos,
    output logic [7:0]                     tail_pos,
    output logic                           px_valid,
    output logic [7:0]                     px_pos,
    output logic                           px_on,
    input  logic                           px_ready
);

    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int IW = $clog2(MAX_LEN);

    typedef enum logic [2:0] {
        S_CLEAR, S_DRAW, S_IDLE, S_SCAN, S_ERASE, S_WRITE, S_HALT
    } state_t;

    state_t          state, state_nxt;
    logic [7:0]      body [MAX_LEN];
    logic [IW-1:0]   head_idx, tail_idx, rd_idx;
    logic [6:0]      clr_cnt;
    logic [LW-1:0]   idx_cnt;
    logic [1:0]      cur_dir, eff_dir;
    logic [7:0]      new_head;
    logic            grow_eff, hit;
    logic            xfer, scan_last, scan_match;

    // Circular-buffer increment; MAX_LEN need not be a power of two.
    function automatic logic [IW-1:0] idx_inc(input logic [IW-1:0] i);
        if (i == IW'(MAX_LEN - 1))
            return '0;
        return i + IW'(1);
    endfunction

    // One cell in direction d; rows wrap mod 8, columns mod 16.
    function automatic logic [7:0] step_pos(input logic [6:0] p, input logic [1:0] d);
        logic [2:0] r;
        logic [3:0] c;
        r = p[6:4];
        c = p[3:0];
        case (d)
            2'b00:   r = r - 3'd1;
            2'b01:   c = c + 4'd1;
            2'b10:   r = r + 3'd1;
            default: c = c - 4'd1;
        endcase
        return {1'b0, r, c};
    endfunction

    // Initial body: slot 0 is the tail, slot INIT_LEN-1 the head, same row.
    function automatic logic [7:0] init_pos(input int i);
        logic [3:0] c;
        c = INIT_HEAD[3:0] - 4'(INIT_LEN - 1 - i);
        return {INIT_HEAD[7:4], c};
    endfunction

    assign head_pos = body[head_idx];
    assign tail_pos = body[tail_idx];
    assign busy     = (state != S_IDLE);
    assign xfer     = px_valid & px_ready;

    // A reversal request is ignored; the snake keeps its current heading.
    assign eff_dir  = (dir == (cur_dir ^ 2'b10)) ? cur_dir : dir;

    // Shared read pointer: walks tail..head for both DRAW and SCAN.
    always_comb begin
        int s;
        s = int'(tail_idx) + int'(idx_cnt);
        if (s >= MAX_LEN)
            s = s - MAX_LEN;
        rd_idx = IW'(s);
    end

    assign scan_last  = (idx_cnt == length - LW'(1));
    // The old tail vacates this step unless growing, so it cannot be hit.
    assign scan_match = (body[rd_idx] == new_head) && !((idx_cnt == '0) && !grow_eff);

    always_comb begin
        state_nxt = state;
        px_valid  = 1'b0;
        px_on     = 1'b0;
        px_pos    = 8'h00;
        case (state)
            S_CLEAR: begin
                px_valid = 1'b1;
                px_pos   = {1'b0, clr_cnt};
                if (px_ready && clr_cnt == 7'h7F)
                    state_nxt = S_DRAW;
            end
            S_DRAW: begin
                px_valid = 1'b1;
                px_on    = 1'b1;
                px_pos   = {1'b0, body[rd_idx][6:0]};
                if (px_ready && idx_cnt == LW'(INIT_LEN - 1))
                    state_nxt = S_IDLE;
            end
            S_IDLE: begin
                if (step)
                    state_nxt = S_SCAN;
            end
            S_SCAN: begin
                if (scan_last) begin
                    if (hit || scan_match)
                        state_nxt = S_HALT;
                    else if (grow_eff)
                        state_nxt = S_WRITE;
                    else
                        state_nxt = S_ERASE;
                end
            end
            S_ERASE: begin
                px_valid = 1'b1;
                px_pos   = {1'b0, tail_pos[6:0]};
                if (px_ready)
                    state_nxt = S_WRITE;
            end
            S_WRITE: begin
                px_valid = 1'b1;
                px_on    = 1'b1;
                px_pos   = {1'b0, new_head[6:0]};
                if (px_ready)
                    state_nxt = S_IDLE;
            end
            S_HALT: begin
                state_nxt = S_HALT;
            end
            default: state_nxt = S_CLEAR;
        endcase
        // Reset drops any in-flight request immediately.
        if (rst)
            px_valid = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_CLEAR;
            clr_cnt   <= '0;
            idx_cnt   <= '0;
            head_idx  <= IW'(INIT_LEN - 1);
            tail_idx  <= '0;
            length    <= LW'(INIT_LEN);
            cur_dir   <= 2'b01;
            grow_eff  <= 1'b0;
            hit       <= 1'b0;
            collision <= 1'b0;
            done      <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= 1'b0;
            case (state)
                S_CLEAR: begin
                    if (xfer)
                        clr_cnt <= clr_cnt + 7'd1;
                end
                S_DRAW: begin
                    if (xfer)
                        idx_cnt <= (idx_cnt == LW'(INIT_LEN - 1)) ? '0 : idx_cnt + LW'(1);
                end
                S_IDLE: begin
                    if (step) begin
                        grow_eff <= grow && (length < LW'(MAX_LEN));
                        cur_dir  <= eff_dir;
                        idx_cnt  <= '0;
                        hit      <= 1'b0;
                    end
                end
                S_SCAN: begin
                    if (scan_match)
                        hit <= 1'b1;
                    if (scan_last) begin
                        idx_cnt <= '0;
                        if (hit || scan_match)
                            collision <= 1'b1;
                    end else begin
                        idx_cnt <= idx_cnt + LW'(1);
                    end
                end
                S_ERASE: begin
                    if (xfer)
                        tail_idx <= idx_inc(tail_idx);
                end
                S_WRITE: begin
                    if (xfer) begin
                        head_idx <= idx_inc(head_idx);
                        if (grow_eff)
                            length <= length + LW'(1);
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // New head position is captured on step acceptance.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && step && !rst)
            new_head <= step_pos(head_pos[6:0], eff_dir);
    end

    // Body store: initial snake on reset, new head on the WRITE transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < INIT_LEN; i++)
                body[i] <= init_pos(i);
        end else if (state == S_WRITE && xfer) begin
            body[idx_inc(head_idx)] <= new_head;
        end
    end

endmodule

// File: tb/tb_snake_body_ctrl.sv
// Testbench for snake_body_ctrl: a queue-based snake model predicts every
// pixel write; a negedge monitor pops and compares each transfer.
module tb_snake_body_ctrl;

    localparam int         MAX_LEN   = 32;
    localparam int         INIT_LEN  = 3;
    localparam logic [7:0] INIT_HEAD = 8'h34;
    localparam int         LW        = $clog2(MAX_LEN + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          step = 1'b0;
    logic [1:0]    dir = 2'b01;
    logic          grow = 1'b0;
    logic          px_ready = 1'b1;
    logic          busy, done, collision, px_valid, px_on;
    logic [LW-1:0] length;
    logic [7:0]    head_pos, tail_pos, px_pos;

    int n_cmp = 0;
    int n_bad = 0;

    logic [8:0] exp_q [$];
    logic [7:0] m_body [$];
    logic [1:0] m_dir;

    snake_body_ctrl #(
        .MAX_LEN   (MAX_LEN),
        .INIT_LEN  (INIT_LEN),
        .INIT_HEAD (INIT_HEAD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .step      (step),
        .dir       (dir),
        .grow      (grow),
        .busy      (busy),
        .done      (done),
        .collision (collision),
        .length    (length),
        .head_pos  (head_pos),
        .tail_pos  (tail_pos),
        .px_valid  (px_valid),
        .px_pos    (px_pos),
        .px_on     (px_on),
        .px_ready  (px_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Scoreboard: each accepted pixel transfer is matched against the model.
    always @(negedge clk) begin
        if (!rst && px_valid === 1'b1 && px_ready === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL px_write: got on=%0b pos=%02h, required no write", px_on, px_pos);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                if ({px_on, px_pos} !== e) begin
                    n_bad++;
                    $display("FAIL px_write: got on=%0b pos=%02h, required on=%0b pos=%02h",
                             px_on, px_pos, e[8], e[7:0]);
                end
            end
        end
    end

    // Reference snake: tail at front of m_body, head at back.
    task automatic model_step(input logic [1:0] d, input logic g, output bit coll);
        logic [1:0] ed;
        logic [7:0] h, nh;
        logic [2:0] r;
        logic [3:0] c;
        bit ge;
        ed = (d == (m_dir ^ 2'b10)) ? m_dir : d;
        m_dir = ed;
        h = m_body[$];
        r = h[6:4];
        c = h[3:0];
        case (ed)
            2'b00:   r = r - 3'd1;
            2'b01:   c = c + 4'd1;
            2'b10:   r = r + 3'd1;
            default: c = c - 4'd1;
        endcase
        nh = {1'b0, r, c};
        ge = g && (m_body.size() < MAX_LEN);
        coll = 0;
        for (int i = (ge ? 0 : 1); i < m_body.size(); i++)
            if (m_body[i] == nh)
                coll = 1;
        if (!coll) begin
            if (!ge) begin
                exp_q.push_back({1'b0, m_body[0]});
                void'(m_body.pop_front());
            end
            exp_q.push_back({1'b1, nh});
            m_body.push_back(nh);
        end
    endtask

    // Pulses step for one cycle; returns in the cycle after acceptance.
    task automatic drive_step(input logic [1:0] d, input logic g, output bit coll);
        @(posedge clk); #1;
        step = 1'b1;
        dir  = d;
        grow = g;
        model_step(d, g, coll);
        @(posedge clk); #1;
        step = 1'b0;
        grow = 1'b0;
    endtask

    // Counts cycles from acceptance (cycle 0) until done is seen.
    task automatic wait_done(input int budget, output int cyc, output bit ok);
        ok  = 0;
        cyc = 1;
        while (cyc < budget) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ok = 1;
                break;
            end
            cyc++;
        end
    endtask

    task automatic test_reset();
        int cyc;
        bit ok;
        @(posedge clk); #1;
        rst = 1'b1; step = 1'b0; grow = 1'b0; px_ready = 1'b1; dir = 2'b01;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (busy !== 1'b1)      begin n_bad++; $display("FAIL rst_busy: got %0b, required 1", busy); end
        n_cmp++; if (done !== 1'b0)      begin n_bad++; $display("FAIL rst_done: got %0b, required 0", done); end
        n_cmp++; if (collision !== 1'b0) begin n_bad++; $display("FAIL rst_collision: got %0b, required 0", collision); end
        n_cmp++; if (px_valid !== 1'b0)  begin n_bad++; $display("FAIL rst_px_valid: got %0b, required 0", px_valid); end
        n_cmp++; if (length !== LW'(INIT_LEN)) begin n_bad++; $display("FAIL rst_length: got %0d, required %0d", length, INIT_LEN); end
        n_cmp++; if (head_pos !== 8'h34) begin n_bad++; $display("FAIL rst_head: got %02h, required 34", head_pos); end
        n_cmp++; if (tail_pos !== 8'h32) begin n_bad++; $display("FAIL rst_tail: got %02h, required 32", tail_pos); end
        exp_q.delete();
        m_body.delete();
        m_body.push_back(8'h32); m_body.push_back(8'h33); m_body.push_back(8'h34);
        m_dir = 2'b01;
        for (int a = 0; a < 128; a++)
            exp_q.push_back({1'b0, 8'(a)});
        for (int i = 0; i < 3; i++)
            exp_q.push_back({1'b1, m_body[i]});
        @(posedge clk); #1;
        rst = 1'b0;
        ok = 0;
        for (cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            if (busy === 1'b0) begin ok = 1; break; end
        end
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL init_idle: busy still %0b after %0d cycles, required 0", busy, cyc); end
        n_cmp++; if (cyc !== 131) begin n_bad++; $display("FAIL init_cycles: got %0d, required 131", cyc); end
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL init_writes: %0d writes missing, required 0", exp_q.size()); end
        n_cmp++; if (length !== 3) begin n_bad++; $display("FAIL init_length: got %0d, required 3", length); end
    endtask

    task automatic test_move();
        int cyc;
        bit ok, coll;
        drive_step(2'b01, 1'b0, coll);
        wait_done(50, cyc, ok);
        n_cmp++; if (!ok || cyc != 6) begin n_bad++; $display("FAIL move_done_cycle: got %0d (seen=%0b), required 6", cyc, ok); end
        n_cmp++; if (head_pos !== 8'h35) begin n_bad++; $display("FAIL move_head: got %02h, required 35", head_pos); end
        n_cmp++; if (tail_pos !== 8'h33) begin n_bad++; $display("FAIL move_tail: got %02h, required 33", tail_pos); end
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL move_writes: %0d missing, required 0", exp_q.size()); end
        @(negedge clk);
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL move_done_pulse: got %0b, required 0", done); end
    endtask

    task automatic test_wrap();
        int cyc;
        bit ok, coll;
        logic [1:0] seq [19];
        for (int i = 0; i < 19; i++)
            seq[i] = (i < 15) ? 2'b01 : 2'b00;
        for (int i = 0; i < 19; i++) begin
            drive_step(seq[i], 1'b0, coll);
            wait_done(50, cyc, ok);
            n_cmp++; if (!ok) begin n_bad++; $display("FAIL wrap_done: step %0d no done, required done", i); end
            if (i == 9) begin
                n_cmp++; if (head_pos !== 8'h3F) begin n_bad++; $display("FAIL wrap_pre: got %02h, required 3f", head_pos); end
            end
            if (i == 10) begin
                n_cmp++; if (head_pos !== 8'h30) begin n_bad++; $display("FAIL wrap_col: got %02h, required 30", head_pos); end
            end
            if (i == 17) begin
                n_cmp++; if (head_pos !== 8'h04) begin n_bad++; $display("FAIL wrap_pre_row: got %02h, required 04", head_pos); end
            end
            if (i == 18) begin
                n_cmp++; if (head_pos !== 8'h74) begin n_bad++; $display("FAIL wrap_row: got %02h, required 74", head_pos); end
            end
        end
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL wrap_writes: %0d missing, required 0", exp_q.size()); end
    endtask

    task automatic test_grow();
        int cyc;
        bit ok, coll;
        logic [1:0] d;
        int want;
        test_reset();
        for (int k = 0; k < 30; k++) begin
            if (k < 11)       d = 2'b01;
            else if (k == 11) d = 2'b10;
            else if (k < 27)  d = 2'b11;
            else if (k == 27) d = 2'b10;
            else              d = 2'b01;
            drive_step(d, 1'b1, coll);
            wait_done(100, cyc, ok);
            n_cmp++; if (!ok) begin n_bad++; $display("FAIL grow_done: step %0d no done, required done", k); end
            want = (3 + k + 1 > MAX_LEN) ? MAX_LEN : 3 + k + 1;
            n_cmp++; if (length !== LW'(want)) begin n_bad++; $display("FAIL grow_length: step %0d got %0d, required %0d", k, length, want); end
            if (k == 0) begin
                n_cmp++; if (cyc != 5) begin n_bad++; $display("FAIL grow_latency: got %0d, required 5", cyc); end
            end
            if (k == 29) begin
                n_cmp++; if (cyc != MAX_LEN + 3) begin n_bad++; $display("FAIL full_latency: got %0d, required %0d", cyc, MAX_LEN + 3); end
            end
        end
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL grow_writes: %0d missing, required 0", exp_q.size()); end
    endtask

    task automatic test_collision();
        int cyc;
        bit ok, coll, seen_done;
        logic [1:0] ds [5];
        logic       gs [5];
        ds = '{2'b01, 2'b01, 2'b10, 2'b11, 2'b00};
        gs = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        test_reset();
        for (int i = 0; i < 4; i++) begin
            drive_step(ds[i], gs[i], coll);
            wait_done(50, cyc, ok);
            n_cmp++; if (!ok) begin n_bad++; $display("FAIL coll_setup: step %0d no done, required done", i); end
        end
        n_cmp++; if (length !== 5) begin n_bad++; $display("FAIL coll_length: got %0d, required 5", length); end
        drive_step(ds[4], gs[4], coll);
        n_cmp++; if (coll !== 1'b1) begin n_bad++; $display("FAIL coll_model: got %0b, required 1", coll); end
        ok = 0;
        seen_done = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (done === 1'b1) seen_done = 1;
            if (collision === 1'b1) begin ok = 1; break; end
        end
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL coll_flag: got %0b, required 1", collision); end
        n_cmp++; if (seen_done) begin n_bad++; $display("FAIL coll_done: got 1, required 0"); end
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            step = (c == 3);
            dir  = 2'b01;
            @(negedge clk);
            n_cmp++;
            if (px_valid !== 1'b0 || busy !== 1'b1 || collision !== 1'b1 || done !== 1'b0) begin
                n_bad++;
                $display("FAIL halt_hold: got valid=%0b busy=%0b coll=%0b done=%0b, required 0 1 1 0",
                         px_valid, busy, collision, done);
            end
        end
        step = 1'b0;
    endtask

    task automatic test_stall();
        int cyc;
        bit ok, coll;
        logic [8:0] held;
        @(posedge clk); #1;
        px_ready = 1'b0;
        drive_step(2'b11, 1'b0, coll);
        ok = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (px_valid === 1'b1) begin ok = 1; break; end
        end
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL stall_valid: got %0b, required 1", px_valid); end
        held = {px_on, px_pos};
        n_cmp++; if (held !== 9'h032) begin n_bad++; $display("FAIL stall_first: got on=%0b pos=%02h, required on=0 pos=32", held[8], held[7:0]); end
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            step = (c == 2);
            dir  = (c == 2) ? 2'b00 : 2'b11;
            @(negedge clk);
            n_cmp++;
            if (px_valid !== 1'b1 || {px_on, px_pos} !== held) begin
                n_bad++;
                $display("FAIL stall_hold: got valid=%0b on=%0b pos=%02h, required valid=1 on=%0b pos=%02h",
                         px_valid, px_on, px_pos, held[8], held[7:0]);
            end
        end
        @(posedge clk); #1;
        step = 1'b0;
        px_ready = 1'b1;
        wait_done(50, cyc, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL stall_done: no done, required done"); end
        n_cmp++; if (head_pos !== 8'h35) begin n_bad++; $display("FAIL stall_head: got %02h, required 35", head_pos); end
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL stall_writes: %0d missing, required 0", exp_q.size()); end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL stall_queued: busy got %0b, required 0", busy); end
        end
    endtask

    initial begin
        test_reset();
        test_move();
        test_wrap();
        test_grow();
        test_collision();
        test_reset();
        test_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
